// File: rtl/rv32i_lsu.sv
// rv32i_lsu: RV32I load/store unit, initiator side of the data-memory port.
//
// Takes one load or store from the MEM stage and checks funct3 and alignment.
// Legal requests become a single bus transaction with a word address, byte
// enables and lane-replicated store data. Loads return the addressed lane,
// sign- or zero-extended.
//
// Handshake: o_mem_req and every request field (o_mem_we, o_mem_addr,
// o_mem_be, o_mem_wdata) stay stable from the first request cycle up to and
// including the cycle in which i_mem_gnt is sampled high. i_mem_gnt is looked
// at only while a request is pending. i_mem_rvalid/i_mem_rdata are looked at
// only for a granted load: in the grant cycle itself, or in any later cycle.
// Pipeline side: i_lsu_req is looked at only in IDLE. o_lsu_busy stalls the
// pipeline until the o_lsu_done cycle, and a new request may be presented in
// that cycle.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   i_lsu_req/we/func3/addr/wdata  memory op presented by the pipeline
//   o_lsu_busy                 combinational stall request
//   o_lsu_done                 one-cycle completion pulse
//   o_lsu_rdata                extended load result, held until the next load
//   o_lsu_fault                one-cycle pulse for misaligned/illegal ops
//   o_mem_req/we/addr/be/wdata request to data memory
//   i_mem_gnt                  memory accepted the request
//   i_mem_rvalid/i_mem_rdata   read response
module rv32i_lsu #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_lsu_req,
    input  logic                  i_lsu_we,
    input  logic [2:0]            i_lsu_func3,
    input  logic [ADDR_WIDTH-1:0] i_lsu_addr,
    input  logic [WIDTH-1:0]      i_lsu_wdata,
    output logic                  o_lsu_busy,
    output logic                  o_lsu_done,
    output logic [WIDTH-1:0]      o_lsu_rdata,
    output logic                  o_lsu_fault,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [3:0]            o_mem_be,
    output logic [WIDTH-1:0]      o_mem_wdata,
    input  logic                  i_mem_gnt,
    input  logic                  i_mem_rvalid,
    input  logic [WIDTH-1:0]      i_mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2
    } state_t;

    state_t     state;
    logic [2:0] func3_q;  // load type, kept for extraction
    logic [1:0] off_q;    // byte offset within the word, kept for extraction

    logic             f3_legal;
    logic             aligned;
    logic             accept;
    logic [3:0]       be_next;
    logic [WIDTH-1:0] wdata_next;

    always_comb begin
        f3_legal = 1'b0;
        case (i_lsu_func3)
            3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
            3'b100, 3'b101:         f3_legal = !i_lsu_we;  // LBU/LHU have no store form
            default:                f3_legal = 1'b0;
        endcase

        aligned = 1'b1;
        case (i_lsu_func3[1:0])
            2'b01:   aligned = !i_lsu_addr[0];
            2'b10:   aligned = (i_lsu_addr[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
    end

    assign accept     = (state == IDLE) && i_lsu_req && f3_legal && aligned;
    assign o_lsu_busy = (state != IDLE) || accept;

    always_comb begin
        be_next    = 4'b1111;
        wdata_next = '0;
        if (i_lsu_we) begin
            case (i_lsu_func3[1:0])
                2'b00: begin
                    be_next    = 4'b0001 << i_lsu_addr[1:0];
                    wdata_next = {4{i_lsu_wdata[7:0]}};
                end
                2'b01: begin
                    be_next    = 4'b0011 << {i_lsu_addr[1], 1'b0};
                    wdata_next = {2{i_lsu_wdata[15:0]}};
                end
                default: begin
                    be_next    = 4'b1111;
                    wdata_next = i_lsu_wdata;
                end
            endcase
        end
    end

    // Pick the addressed byte/halfword out of the returned word and extend it.
    function automatic logic [WIDTH-1:0] extract(input logic [2:0]       f3,
                                                 input logic [1:0]       off,
                                                 input logic [WIDTH-1:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'b0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'b0, h};
            default: return word;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            func3_q     <= '0;
            off_q       <= '0;
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_be    <= '0;
            o_mem_wdata <= '0;
            o_lsu_done  <= 1'b0;
            o_lsu_fault <= 1'b0;
            o_lsu_rdata <= '0;
        end else begin
            o_lsu_done  <= 1'b0;
            o_lsu_fault <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state       <= REQ;
                        o_mem_req   <= 1'b1;
                        o_mem_we    <= i_lsu_we;
                        o_mem_addr  <= {i_lsu_addr[ADDR_WIDTH-1:2], 2'b00};
                        o_mem_be    <= be_next;
                        o_mem_wdata <= wdata_next;
                        func3_q     <= i_lsu_func3;
                        off_q       <= i_lsu_addr[1:0];
                    end else if (i_lsu_req) begin
                        o_lsu_fault <= 1'b1;
                    end
                end
                REQ: begin
                    if (i_mem_gnt) begin
                        o_mem_req <= 1'b0;
                        o_mem_we  <= 1'b0;
                        if (o_mem_we) begin
                            state      <= IDLE;
                            o_lsu_done <= 1'b1;
                        end else if (i_mem_rvalid) begin
                            // Response in the grant cycle: skip WAIT_R.
                            state       <= IDLE;
                            o_lsu_rdata <= extract(func3_q, off_q, i_mem_rdata);
                            o_lsu_done  <= 1'b1;
                        end else begin
                            state <= WAIT_R;
                        end
                    end
                end
                WAIT_R: begin
                    if (i_mem_rvalid) begin
                        state       <= IDLE;
                        o_lsu_rdata <= extract(func3_q, off_q, i_mem_rdata);
                        o_lsu_done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_lsu.sv
// tb_rv32i_lsu: self-checking bench for rv32i_lsu.
// The driver tasks play both the pipeline and the memory, and set the
// expected per-cycle outputs from a transaction-level model; one compare
// process checks the DUT against them on every falling clock edge.
module tb_rv32i_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_lsu_req;
    logic        i_lsu_we;
    logic [2:0]  i_lsu_func3;
    logic [31:0] i_lsu_addr;
    logic [31:0] i_lsu_wdata;
    logic        o_lsu_busy;
    logic        o_lsu_done;
    logic [31:0] o_lsu_rdata;
    logic        o_lsu_fault;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [3:0]  o_mem_be;
    logic [31:0] o_mem_wdata;
    logic        i_mem_gnt;
    logic        i_mem_rvalid;
    logic [31:0] i_mem_rdata;

    rv32i_lsu #(.WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_lsu_req    (i_lsu_req),
        .i_lsu_we     (i_lsu_we),
        .i_lsu_func3  (i_lsu_func3),
        .i_lsu_addr   (i_lsu_addr),
        .i_lsu_wdata  (i_lsu_wdata),
        .o_lsu_busy   (o_lsu_busy),
        .o_lsu_done   (o_lsu_done),
        .o_lsu_rdata  (o_lsu_rdata),
        .o_lsu_fault  (o_lsu_fault),
        .o_mem_req    (o_mem_req),
        .o_mem_we     (o_mem_we),
        .o_mem_addr   (o_mem_addr),
        .o_mem_be     (o_mem_be),
        .o_mem_wdata  (o_mem_wdata),
        .i_mem_gnt    (i_mem_gnt),
        .i_mem_rvalid (i_mem_rvalid),
        .i_mem_rdata  (i_mem_rdata)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int vectors     = 0;
    int miscompares = 0;
    int busy_cnt    = 0;
    logic chk_en    = 1'b0;

    logic        exp_busy, exp_req, exp_we, exp_done, exp_fault;
    logic [31:0] exp_addr, exp_wdata, exp_rdata;
    logic [3:0]  exp_be;
    logic        nxt_done, nxt_fault, nxt_rd_vld;
    logic [31:0] seen_addr, seen_wdata;
    logic [3:0]  seen_be;
    logic [31:0] exp_q[$];  // expected load results, in completion order

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic op_ok(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        int sz;
        if (we && f3 > 3'd2) return 1'b0;
        if (!we && (f3 == 3'd3 || f3 > 3'd5)) return 1'b0;
        sz = 1 << f3[1:0];
        return (int'(addr[1:0]) % sz) == 0;
    endfunction

    function automatic logic [3:0] model_be(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        int sz;
        if (!we) return 4'hF;
        sz = 1 << f3[1:0];
        return 4'(((1 << sz) - 1) << addr[1:0]);
    endfunction

    function automatic logic [31:0] model_wdata(input logic we, input logic [2:0] f3, input logic [31:0] wdata);
        int sz;
        logic [31:0] r;
        if (!we) return 32'h0;
        sz = 1 << f3[1:0];
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wdata[8*(i % sz) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] word);
        int sz;
        logic [31:0] v, mask;
        sz = 1 << f3[1:0];
        if (sz == 4) return word;
        v    = word >> (8 * int'(addr[1:0]));
        mask = (32'd1 << (8 * sz)) - 32'd1;
        v    = v & mask;
        if (!f3[2] && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",     32'(o_lsu_busy),  32'(exp_busy));
            chk("mem_req",  32'(o_mem_req),   32'(exp_req));
            chk("done",     32'(o_lsu_done),  32'(exp_done));
            chk("fault",    32'(o_lsu_fault), 32'(exp_fault));
            chk("rdata",    o_lsu_rdata,      exp_rdata);
            if (exp_req) begin
                chk("mem_we",    32'(o_mem_we), 32'(exp_we));
                chk("mem_addr",  o_mem_addr,    exp_addr);
                chk("mem_be",    32'(o_mem_be), 32'(exp_be));
                chk("mem_wdata", o_mem_wdata,   exp_wdata);
                seen_addr  = o_mem_addr;
                seen_be    = o_mem_be;
                seen_wdata = o_mem_wdata;
            end
            if (o_lsu_busy) busy_cnt++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
        exp_done  = nxt_done;
        exp_fault = nxt_fault;
        if (nxt_rd_vld) exp_rdata = exp_q.pop_front();
        nxt_done   = 1'b0;
        nxt_fault  = 1'b0;
        nxt_rd_vld = 1'b0;
    endtask

    // Pipeline-side junk while the unit is busy; it must be ignored.
    task automatic busy_junk();
        i_lsu_req   = 1'($urandom);
        i_lsu_we    = 1'($urandom);
        i_lsu_func3 = 3'($urandom);
        i_lsu_addr  = $urandom;
        i_lsu_wdata = $urandom;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            step();
            busy_junk();
            i_lsu_req    = 1'b0;
            i_mem_gnt    = 1'($urandom);
            i_mem_rvalid = 1'($urandom);
            i_mem_rdata  = $urandom;
            exp_busy     = 1'b0;
            exp_req      = 1'b0;
        end
    endtask

    // One pipeline op; g = cycles before grant, r = cycles from grant to rvalid.
    task automatic op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, input int g, input int r, input logic [31:0] word);
        step();
        i_lsu_req    = 1'b1;
        i_lsu_we     = we;
        i_lsu_func3  = f3;
        i_lsu_addr   = addr;
        i_lsu_wdata  = wdata;
        i_mem_gnt    = 1'($urandom);
        i_mem_rvalid = 1'($urandom);
        i_mem_rdata  = $urandom;
        exp_req      = 1'b0;
        if (!op_ok(we, f3, addr)) begin
            exp_busy  = 1'b0;
            nxt_fault = 1'b1;
            return;
        end
        exp_busy = 1'b1;
        for (int k = 0; k <= g; k++) begin
            step();
            busy_junk();
            i_mem_gnt    = (k == g);
            i_mem_rvalid = !we && (k == g) && (r == 0);
            i_mem_rdata  = i_mem_rvalid ? word : $urandom;
            exp_busy     = 1'b1;
            exp_req      = 1'b1;
            exp_we       = we;
            exp_addr     = addr & 32'hFFFF_FFFC;
            exp_be       = model_be(we, f3, addr);
            exp_wdata    = model_wdata(we, f3, wdata);
        end
        if (!we) begin
            for (int j = 1; j <= r; j++) begin
                step();
                busy_junk();
                i_mem_gnt    = 1'($urandom);
                i_mem_rvalid = (j == r);
                i_mem_rdata  = i_mem_rvalid ? word : $urandom;
                exp_busy     = 1'b1;
                exp_req      = 1'b0;
            end
            exp_q.push_back(model_load(f3, addr, word));
            nxt_rd_vld = 1'b1;
        end
        nxt_done = 1'b1;
    endtask

    task automatic lit_load(input string name, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] lit);
        op(1'b0, f3, addr, $urandom, 1, 1, 32'h80FF_1234);
        idle(1);
        @(negedge clk);
        chk(name, o_lsu_rdata, lit);
    endtask

    task automatic reset_in_wait();
        step();
        i_lsu_req = 1'b1; i_lsu_we = 1'b0; i_lsu_func3 = 3'b010;
        i_lsu_addr = 32'h40; i_lsu_wdata = $urandom;
        i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0;
        exp_busy = 1'b1; exp_req = 1'b0;
        step();
        busy_junk();
        i_mem_gnt = 1'b1; i_mem_rvalid = 1'b0;
        exp_busy = 1'b1; exp_req = 1'b1; exp_we = 1'b0;
        exp_addr = 32'h40; exp_be = 4'hF; exp_wdata = 32'h0;
        step();
        busy_junk();
        i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0;
        exp_busy = 1'b1; exp_req = 1'b0;
        @(negedge clk);
        #2;
        chk_en    = 1'b0;
        i_lsu_req = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("rst_busy",  32'(o_lsu_busy),  32'h0);
        chk("rst_req",   32'(o_mem_req),   32'h0);
        chk("rst_we",    32'(o_mem_we),    32'h0);
        chk("rst_addr",  o_mem_addr,       32'h0);
        chk("rst_be",    32'(o_mem_be),    32'h0);
        chk("rst_wdata", o_mem_wdata,      32'h0);
        chk("rst_done",  32'(o_lsu_done),  32'h0);
        chk("rst_fault", 32'(o_lsu_fault), 32'h0);
        chk("rst_rdata", o_lsu_rdata,      32'h0);
        exp_rdata = 32'h0;
        nxt_done = 1'b0; nxt_fault = 1'b0; nxt_rd_vld = 1'b0;
        @(posedge clk);
        #1;
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = $urandom;
        @(negedge clk);
        #2;
        rst_n  = 1'b1;
        chk_en = 1'b1;
        idle(2);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0;
        i_lsu_req = 1'b0; i_lsu_we = 1'b0; i_lsu_func3 = 3'b0;
        i_lsu_addr = 32'h0; i_lsu_wdata = 32'h0;
        i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = 32'h0;
        exp_busy = 1'b0; exp_req = 1'b0; exp_we = 1'b0; exp_done = 1'b0; exp_fault = 1'b0;
        exp_addr = 32'h0; exp_wdata = 32'h0; exp_rdata = 32'h0; exp_be = 4'h0;
        nxt_done = 1'b0; nxt_fault = 1'b0; nxt_rd_vld = 1'b0;
        seen_addr = 32'h0; seen_wdata = 32'h0; seen_be = 4'h0;

        #12;
        chk("init_req",   32'(o_mem_req),   32'h0);
        chk("init_done",  32'(o_lsu_done),  32'h0);
        chk("init_fault", 32'(o_lsu_fault), 32'h0);
        chk("init_rdata", o_lsu_rdata,      32'h0);
        chk("init_be",    32'(o_mem_be),    32'h0);
        @(negedge clk);
        #2;
        rst_n  = 1'b1;
        chk_en = 1'b1;
        idle(2);

        // SW with immediate grant
        busy_cnt = 0;
        op(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 0, 0, 32'h0);
        idle(1);
        @(negedge clk);
        chk("sw_busy_cycles", 32'(busy_cnt), 32'd2);
        chk("sw_addr",  seen_addr,      32'h10);
        chk("sw_be",    32'(seen_be),   32'hF);
        chk("sw_wdata", seen_wdata,     32'hDEAD_BEEF);

        op(1'b1, 3'b000, 32'h13, 32'h0000_00A5, 1, 0, 32'h0);
        idle(1);
        chk("sb_be",    32'(seen_be), 32'h8);
        chk("sb_wdata", seen_wdata,   32'hA5A5_A5A5);
        op(1'b1, 3'b001, 32'h22, 32'h1234_5678, 0, 0, 32'h0);
        idle(1);
        chk("sh_be",    32'(seen_be), 32'hC);
        chk("sh_wdata", seen_wdata,   32'h5678_5678);

        // Load extraction against hand-computed values
        lit_load("lb",  3'b000, 32'h13, 32'hFFFF_FF80);
        lit_load("lbu", 3'b100, 32'h13, 32'h0000_0080);
        lit_load("lh",  3'b001, 32'h12, 32'hFFFF_80FF);
        lit_load("lhu", 3'b101, 32'h10, 32'h0000_1234);
        lit_load("lw",  3'b010, 32'h10, 32'h80FF_1234);

        // Faults: misaligned word/half, illegal funct3, store with load-only funct3
        op(1'b0, 3'b010, 32'h02, 32'h0, 0, 0, 32'h0);
        idle(1);
        op(1'b0, 3'b001, 32'h05, 32'h0, 0, 0, 32'h0);
        op(1'b0, 3'b011, 32'h10, 32'h0, 0, 0, 32'h0);
        op(1'b1, 3'b100, 32'h10, 32'h0, 0, 0, 32'h0);
        idle(2);

        // Held grant and held response, then same-cycle grant+rvalid
        op(1'b0, 3'b010, 32'h20, 32'h0, 3, 4, 32'hCAFE_F00D);
        op(1'b0, 3'b000, 32'h21, 32'h0, 0, 0, 32'h0000_8000);
        // Back-to-back store then load
        op(1'b1, 3'b010, 32'h30, 32'h1111_2222, 0, 0, 32'h0);
        op(1'b0, 3'b101, 32'h32, 32'h0, 2, 1, 32'h9876_5432);
        idle(2);

        reset_in_wait();
        op(1'b0, 3'b010, 32'h44, 32'h0, 0, 1, 32'h0BAD_C0DE);
        idle(1);
        @(negedge clk);
        chk("post_rst_lw", o_lsu_rdata, 32'h0BAD_C0DE);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            op(1'($urandom), 3'($urandom_range(0, 7)), $urandom, $urandom,
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
            idle($urandom_range(0, 2));
        end
        idle(3);
        chk("exp_q_drained", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
